// File: rtl/pixel_reorder_queue.sv
// Multi-channel pixel reorder queue: per-engine FIFOs re-emitted in strict raster order.
// The block owns the expected raster coordinate and pops whichever channel head matches it.
module pixel_reorder_queue #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned RGB_SIZE   = 24,
    parameter int unsigned DEPTH      = 8,
    parameter int unsigned NUM_CH     = 4,
    parameter int unsigned H_RES      = 640,
    parameter int unsigned V_RES      = 480,
    parameter int unsigned DEDUP      = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_CH-1:0]              in_valid,
    output logic [NUM_CH-1:0]              in_ready,
    input  logic [NUM_CH*RGB_SIZE-1:0]     in_colour,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   in_x,
    input  logic [NUM_CH*DATA_WIDTH-1:0]   in_y,
    output logic                           out_valid,
    input  logic                           out_ready,
    output logic [RGB_SIZE-1:0]            out_colour,
    output logic [DATA_WIDTH-1:0]          out_x,
    output logic [DATA_WIDTH-1:0]          out_y,
    output logic                           out_sof,
    output logic                           out_eol,
    output logic [NUM_CH-1:0]              full,
    output logic [NUM_CH-1:0]              empty,
    output logic [15:0]                    drop_count,
    output logic                           deadlock
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = RGB_SIZE + 2 * DATA_WIDTH;
    localparam int unsigned IDX_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int unsigned NDROP_W = $clog2(NUM_CH + 1);

    logic [ENTRY_W-1:0]    head [NUM_CH];
    logic [NUM_CH-1:0]     store;
    logic [NUM_CH-1:0]     drop;
    logic [NUM_CH-1:0]     match;
    logic [NUM_CH-1:0]     pop;
    logic                  any_match;
    logic                  load;
    logic [IDX_W-1:0]      win;
    logic [NDROP_W-1:0]    ndrop;
    logic [16:0]           drop_sum;
    logic [DATA_WIDTH-1:0] ex;
    logic [DATA_WIDTH-1:0] ey;
    logic                  ex_last;
    logic                  ey_last;

    assign ex_last = (ex == DATA_WIDTH'(H_RES - 1));
    assign ey_last = (ey == DATA_WIDTH'(V_RES - 1));

    // Per-channel FIFO, dedup tracking and head match against the expected coordinate.
    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [ENTRY_W-1:0]    mem [DEPTH];
        logic [PTR_W-1:0]      wr_ptr;
        logic [PTR_W-1:0]      rd_ptr;
        logic [CNT_W-1:0]      count;
        logic [DATA_WIDTH-1:0] last_x;
        logic [DATA_WIDTH-1:0] last_y;
        logic                  last_v;
        logic [DATA_WIDTH-1:0] cx;
        logic [DATA_WIDTH-1:0] cy;
        logic [RGB_SIZE-1:0]   ccol;
        logic                  push;
        logic                  dup;

        assign cx   = in_x[g*DATA_WIDTH +: DATA_WIDTH];
        assign cy   = in_y[g*DATA_WIDTH +: DATA_WIDTH];
        assign ccol = in_colour[g*RGB_SIZE +: RGB_SIZE];

        assign full[g]     = (count == CNT_W'(DEPTH));
        assign empty[g]    = (count == '0);
        assign in_ready[g] = !full[g];

        assign push     = in_valid[g] && in_ready[g];
        assign dup      = (DEDUP != 0) && last_v && (cx == last_x) && (cy == last_y);
        assign store[g] = push && !dup;
        assign drop[g]  = push && dup;

        assign head[g]  = mem[rd_ptr];
        assign match[g] = !empty[g]
                          && (head[g][2*DATA_WIDTH-1:DATA_WIDTH] == ex)
                          && (head[g][DATA_WIDTH-1:0] == ey);

        always_ff @(posedge clk) begin
            if (store[g]) begin
                mem[wr_ptr] <= {ccol, cx, cy};
            end
        end

        always_ff @(posedge clk) begin
            if (reset) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
                last_x <= '0;
                last_y <= '0;
                last_v <= 1'b0;
            end else begin
                if (store[g]) begin
                    wr_ptr <= wr_ptr + 1'b1;
                    last_x <= cx;
                    last_y <= cy;
                    last_v <= 1'b1;
                end
                if (pop[g]) begin
                    rd_ptr <= rd_ptr + 1'b1;
                end
                count <= count + CNT_W'(store[g]) - CNT_W'(pop[g]);
            end
        end
    end

    // Lowest-index matching channel wins the output register.
    always_comb begin
        any_match = 1'b0;
        win       = '0;
        ndrop     = '0;
        pop       = '0;
        for (int c = NUM_CH - 1; c >= 0; c--) begin
            if (match[c]) begin
                any_match = 1'b1;
                win       = IDX_W'(c);
            end
        end
        load = (!out_valid || out_ready) && any_match;
        for (int c = 0; c < NUM_CH; c++) begin
            pop[c] = load && (win == IDX_W'(c));
            ndrop  = ndrop + NDROP_W'(drop[c]);
        end
    end

    assign drop_sum = {1'b0, drop_count} + 17'(ndrop);

    // Output register, raster counter, drop counter and deadlock flag.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid  <= 1'b0;
            out_sof    <= 1'b0;
            out_eol    <= 1'b0;
            out_colour <= '0;
            out_x      <= '0;
            out_y      <= '0;
            ex         <= '0;
            ey         <= '0;
            drop_count <= '0;
            deadlock   <= 1'b0;
        end else begin
            if (load) begin
                out_valid  <= 1'b1;
                out_colour <= head[win][ENTRY_W-1:2*DATA_WIDTH];
                out_x      <= head[win][2*DATA_WIDTH-1:DATA_WIDTH];
                out_y      <= head[win][DATA_WIDTH-1:0];
                out_sof    <= (ex == '0) && (ey == '0);
                out_eol    <= ex_last;
                if (ex_last) begin
                    ex <= '0;
                    ey <= ey_last ? '0 : ey + 1'b1;
                end else begin
                    ex <= ex + 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
                out_sof   <= 1'b0;
                out_eol   <= 1'b0;
            end

            drop_count <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

            if (any_match) begin
                deadlock <= 1'b0;
            end else if (&full) begin
                deadlock <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_pixel_reorder_queue.sv
// Directed bench for pixel_reorder_queue on a 4x2 raster with two engine channels.
module tb_pixel_reorder_queue;

    localparam int unsigned DW  = 10;
    localparam int unsigned CW  = 24;
    localparam int unsigned NCH = 2;

    logic              clk;
    logic              reset;
    logic [NCH-1:0]    in_valid;
    logic [NCH-1:0]    in_ready;
    logic [NCH*CW-1:0] in_colour;
    logic [NCH*DW-1:0] in_x;
    logic [NCH*DW-1:0] in_y;
    logic              out_valid;
    logic              out_ready;
    logic [CW-1:0]     out_colour;
    logic [DW-1:0]     out_x;
    logic [DW-1:0]     out_y;
    logic              out_sof;
    logic              out_eol;
    logic [NCH-1:0]    full;
    logic [NCH-1:0]    empty;
    logic [15:0]       drop_count;
    logic              deadlock;

    int vec_count = 0;
    int err_count = 0;

    pixel_reorder_queue #(
        .DATA_WIDTH(DW), .RGB_SIZE(CW), .DEPTH(8), .NUM_CH(NCH),
        .H_RES(4), .V_RES(2), .DEDUP(1)
    ) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_colour(in_colour), .in_x(in_x), .in_y(in_y),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_colour(out_colour), .out_x(out_x), .out_y(out_y),
        .out_sof(out_sof), .out_eol(out_eol),
        .full(full), .empty(empty),
        .drop_count(drop_count), .deadlock(deadlock)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int c, input int x, input int y, input logic [CW-1:0] col);
        in_valid[c]          = 1'b1;
        in_x[c*DW +: DW]     = DW'(x);
        in_y[c*DW +: DW]     = DW'(y);
        in_colour[c*CW +: CW] = col;
    endtask

    task automatic idle();
        in_valid = '0;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vec_count++;
        assert (obs === exp) else begin
            err_count++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_pix(input string tag, input int x, input int y);
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        chk({tag, "_x"}, 32'(out_x), 32'(x));
        chk({tag, "_y"}, 32'(out_y), 32'(y));
    endtask

    initial begin
        reset     = 1'b1;
        out_ready = 1'b1;
        in_valid  = '0;
        in_colour = '0;
        in_x      = '0;
        in_y      = '0;
        step();
        step();
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_empty", 32'(empty), 32'h3);
        chk("rst_full", 32'(full), 32'h0);
        chk("rst_in_ready", 32'(in_ready), 32'h3);
        chk("rst_drop", 32'(drop_count), 32'h0);
        chk("rst_deadlock", 32'(deadlock), 32'h0);
        chk("rst_out_x", 32'(out_x), 32'h0);
        reset = 1'b0;

        // Interleaved row 0 across two channels.
        drive(0, 0, 0, 24'hA00000);
        drive(1, 1, 0, 24'hB10000);
        step();
        chk("r0_latency", 32'(out_valid), 32'd0);
        drive(0, 2, 0, 24'hA20000);
        drive(1, 3, 0, 24'hB30000);
        step();
        idle();
        chk_pix("r0_p0", 0, 0);
        chk("r0_p0_sof", 32'(out_sof), 32'd1);
        chk("r0_p0_eol", 32'(out_eol), 32'd0);
        chk("r0_p0_col", 32'(out_colour), 32'hA00000);
        step();
        chk_pix("r0_p1", 1, 0);
        chk("r0_p1_sof", 32'(out_sof), 32'd0);
        chk("r0_p1_col", 32'(out_colour), 32'hB10000);
        step();
        chk_pix("r0_p2", 2, 0);
        chk("r0_p2_col", 32'(out_colour), 32'hA20000);
        step();
        chk_pix("r0_p3", 3, 0);
        chk("r0_p3_eol", 32'(out_eol), 32'd1);
        step();
        chk("r0_drain_valid", 32'(out_valid), 32'd0);
        chk("r0_drain_empty", 32'(empty), 32'h3);

        // Row 1 from channel 1, ending in the frame wrap.
        drive(1, 0, 1, 24'h010101);
        step();
        chk("r1_latency", 32'(out_valid), 32'd0);
        drive(1, 1, 1, 24'h111111);
        step();
        chk_pix("r1_p0", 0, 1);
        drive(1, 2, 1, 24'h212121);
        step();
        chk_pix("r1_p1", 1, 1);
        drive(1, 3, 1, 24'h313131);
        step();
        chk_pix("r1_p2", 2, 1);
        idle();
        step();
        chk_pix("r1_p3", 3, 1);
        chk("r1_p3_eol", 32'(out_eol), 32'd1);

        // Duplicate (0,0) on channel 0 is dropped; the wrapped (0,0) carries sof.
        drive(0, 0, 0, 24'hD00000);
        step();
        chk("dup_first_drop", 32'(drop_count), 32'd0);
        chk("dup_gap_valid", 32'(out_valid), 32'd0);
        drive(0, 0, 0, 24'hD00001);
        step();
        idle();
        chk("dup_drop", 32'(drop_count), 32'd1);
        chk_pix("dup_out", 0, 0);
        chk("dup_sof", 32'(out_sof), 32'd1);
        chk("dup_col", 32'(out_colour), 32'hD00000);
        step();
        chk("dup_single_valid", 32'(out_valid), 32'd0);
        chk("dup_single_empty", 32'(empty), 32'h3);

        // Downstream stall for five cycles with matches pending.
        out_ready = 1'b0;
        drive(0, 1, 0, 24'h000111);
        drive(1, 2, 0, 24'h000222);
        step();
        idle();
        chk("stall_latency", 32'(out_valid), 32'd0);
        step();
        chk_pix("stall_first", 1, 0);
        drive(0, 3, 0, 24'h000333);
        for (int i = 0; i < 5; i++) begin
            step();
            idle();
            chk_pix("stall_hold", 1, 0);
            chk("stall_hold_col", 32'(out_colour), 32'h000111);
        end
        chk("stall_no_pop", 32'(empty), 32'h0);
        out_ready = 1'b1;
        step();
        chk_pix("stall_rel0", 2, 0);
        chk("stall_rel0_col", 32'(out_colour), 32'h000222);
        step();
        chk_pix("stall_rel1", 3, 0);
        chk("stall_rel1_eol", 32'(out_eol), 32'd1);
        step();
        chk("stall_end_valid", 32'(out_valid), 32'd0);

        // Advance to (2,1) with a queued pixel and a second drop, then reset mid-frame.
        drive(1, 0, 1, 24'h0A0A0A);
        drive(0, 3, 1, 24'h0B0B0B);
        step();
        drive(1, 1, 1, 24'h0C0C0C);
        drive(0, 3, 1, 24'h0D0D0D);
        step();
        idle();
        chk_pix("mid_p0", 0, 1);
        step();
        chk_pix("mid_p1", 1, 1);
        chk("mid_drop", 32'(drop_count), 32'd2);
        chk("mid_queued", 32'(empty), 32'h2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_rst_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_empty", 32'(empty), 32'h3);
        chk("mid_rst_drop", 32'(drop_count), 32'd0);
        drive(1, 0, 0, 24'hEEEEEE);
        step();
        idle();
        step();
        chk_pix("mid_restart", 0, 0);
        chk("mid_restart_sof", 32'(out_sof), 32'd1);

        // Channel 0 fills with no (0,0) queued; channel 1 unblocks it.
        reset = 1'b1;
        step();
        reset = 1'b0;
        drive(0, 1, 0, 24'h100000);
        step();
        drive(0, 2, 0, 24'h200000);
        step();
        drive(0, 3, 0, 24'h300000);
        step();
        drive(0, 0, 1, 24'h010000);
        step();
        drive(0, 1, 1, 24'h110000);
        step();
        drive(0, 2, 1, 24'h210000);
        step();
        drive(0, 3, 1, 24'h310000);
        step();
        drive(0, 1, 0, 24'h120000);
        step();
        chk("full_flag", 32'(full), 32'h1);
        chk("full_in_ready", 32'(in_ready), 32'h2);
        chk("full_out_valid", 32'(out_valid), 32'd0);
        chk("full_deadlock", 32'(deadlock), 32'd0);
        drive(0, 2, 0, 24'hBAD000);
        drive(1, 0, 0, 24'h00C0DE);
        step();
        idle();
        chk("full_hold_flag", 32'(full), 32'h1);
        chk("full_push_latency", 32'(out_valid), 32'd0);
        step();
        chk_pix("full_unblock", 0, 0);
        chk("full_unblock_col", 32'(out_colour), 32'h00C0DE);
        step();
        chk_pix("drain_0", 1, 0);
        chk("drain_0_col", 32'(out_colour), 32'h100000);
        step();
        chk_pix("drain_1", 2, 0);
        step();
        chk_pix("drain_2", 3, 0);
        step();
        chk_pix("drain_3", 0, 1);
        step();
        chk_pix("drain_4", 1, 1);
        step();
        chk_pix("drain_5", 2, 1);
        step();
        chk_pix("drain_6", 3, 1);
        chk("drain_6_col", 32'(out_colour), 32'h310000);
        step();
        chk("drain_blocked_valid", 32'(out_valid), 32'd0);
        chk("drain_left", 32'(empty), 32'h2);
        chk("drain_not_full", 32'(full), 32'h0);

        // Both channels full of row-1 pixels while (0,0) is expected.
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int i = 0; i < 8; i++) begin
            drive(0, (i % 2 == 0) ? 2 : 3, 1, 24'h0000F0);
            drive(1, (i % 2 == 0) ? 3 : 2, 1, 24'h0000F1);
            step();
        end
        idle();
        chk("dl_full", 32'(full), 32'h3);
        chk("dl_not_yet", 32'(deadlock), 32'd0);
        step();
        chk("dl_set", 32'(deadlock), 32'd1);
        chk("dl_no_out", 32'(out_valid), 32'd0);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("dl_rst", 32'(deadlock), 32'd0);
        chk("dl_rst_empty", 32'(empty), 32'h3);

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule

// File: doc/pixel_reorder_queue.md
Name: pixel_reorder_queue

Overview:
- Multi-channel successor to the single-engine pixel queue: NUM_CH render engines each push (colour, x, y) into a private FIFO; the block re-emits pixels in strict raster order to the combinator/VGA path.
- Raster position is tracked internally: the block owns the expected-coordinate counter instead of taking a check coordinate from outside.
- Single-clock-edge design (posedge only); ready/valid handshakes on both sides; per-channel duplicate suppression, occupancy flags and a deadlock flag.

Parameters:
- DATA_WIDTH, 10, coordinate width (x and y).
- RGB_SIZE, 24, colour width.
- DEPTH, 8, entries per channel FIFO; power of two, >= 2.
- NUM_CH, 4, number of engine input channels, 1..8.
- H_RES, 640, pixels per line; x wraps at H_RES-1.
- V_RES, 480, lines per frame; y wraps at V_RES-1.
- DEDUP, 1, 1 = drop input equal to the last accepted coordinate on that channel.

Ports:
- clk  in  1  clock, all logic on rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  NUM_CH  per-channel pixel valid.
- in_ready  out  NUM_CH  per-channel accept; equals !full[c].
- in_colour  in  NUM_CH*RGB_SIZE  channel c at bits [c*RGB_SIZE +: RGB_SIZE].
- in_x  in  NUM_CH*DATA_WIDTH  packed like in_colour.
- in_y  in  NUM_CH*DATA_WIDTH  packed like in_colour.
- out_valid  out  1  output register holds a pixel.
- out_ready  in  1  downstream accepts.
- out_colour  out  RGB_SIZE  registered colour.
- out_x  out  DATA_WIDTH  registered x.
- out_y  out  DATA_WIDTH  registered y.
- out_sof  out  1  high with the pixel at (0,0).
- out_eol  out  1  high with any pixel where x == H_RES-1.
- full  out  NUM_CH  count[c] == DEPTH.
- empty  out  NUM_CH  count[c] == 0.
- drop_count  out  16  saturating count of dedup drops, all channels.
- deadlock  out  1  registered; every non-empty head mismatches and no channel can accept.

Behaviour:
- Reset: pointers, counts, expected (ex,ey)=(0,0), out_valid/out_sof/out_eol=0, out_colour/out_x/out_y=0, dedup-valid flags=0, drop_count=0, deadlock=0. FIFO storage is not cleared. Reset mid-frame discards all queued pixels and restarts at (0,0).
- Count per channel is log2(DEPTH)+1 bits; all DEPTH entries are usable. Pointers wrap naturally modulo DEPTH.
- Write: handshake when in_valid[c] && in_ready[c].
  - DEDUP=1, last-valid[c] set and (x,y) equal to last accepted: handshake completes, nothing stored, drop_count +1 (saturating at 0xFFFF).
  - Otherwise: store at wr_ptr, update last (x,y) and set last-valid.
- in_ready depends only on registered count. A full channel does not accept even if it pops in the same cycle.
- Match: channel c matches when !empty[c] and head (x,y) == (ex,ey). If several match, the lowest index wins.
- Load: when (!out_valid || out_ready) and a match exists, in the same edge:
  - the output register loads the head and sets out_valid=1;
  - the winning FIFO pops;
  - (ex,ey) advances: ex+1; at ex==H_RES-1, ex=0 and ey+1; at ey==V_RES-1 with end of line, ey=0.
- Hold: out_valid && !out_ready holds the output register stable. If there is no match and out_ready is high, out_valid falls to 0.
- Non-matching heads block their channel (no skipping or reordering within a channel).
- Latency: input handshake at edge k gives out_valid at edge k+1 at the earliest. Throughput is 1 pixel/clk.
- Simultaneous push and pop on the same channel: count unchanged, both take effect.
- deadlock: set at edge when all channels are full and no match; cleared on the first match or on reset.

Test Plan:
- H_RES=4, V_RES=2, NUM_CH=2. Ch0 sends (0,0),(2,0); ch1 sends (1,0),(3,0) -> out x sequence 0,1,2,3 at y=0; out_sof on (0,0); out_eol on (3,0).
- Ch0 pushes 8 pixels (1,0)..(3,1) with no (0,0) anywhere -> after 8 handshakes full[0]=1, in_ready[0]=0, out_valid=0. Ch1 pushes (0,0) -> out (0,0) next edge; ch0 drains in order.
- Ch0 sends (0,0) twice back-to-back -> second is dropped, drop_count=1, exactly one (0,0) output.
- out_ready held 0 for 5 cycles with matches pending -> out_x/out_y/out_colour stable, no pops. Release -> 1 pixel/clk resumes.
- Both channels full with heads (2,1),(3,1) while expecting (0,0) -> deadlock=1 one edge later.
- Reset asserted mid-frame at expected (2,1) -> next output must be (0,0); counts=0, drop_count=0.
- Last pixel (3,1) emitted -> expected wraps to (0,0); next (0,0) carries out_sof=1.
